// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID decode to control word, ID/EX, EX/MEM, MEM/WB control
// registers, load-use stall/bubble, EX flush, saturating illegal-op counter.
// Ports: ID fields in (id_valid_i, opcode/funct/rs/rd), flush_i in;
// stall_o, illegal_o, illegal_cnt_o, per-stage ex_/mem_/wb_ controls out.
module pipe_ctrl_unit #(
   parameter int REG_AW    = 5,
   parameter bit HAZARD_EN = 1'b1,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid_i,
   input  logic [6:0]        opcode_i,
   input  logic [2:0]        funct3_i,
   input  logic              funct7b5_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              illegal_o,
   output logic [CNT_W-1:0]  illegal_cnt_o,
   output logic              ex_alusrc_o,
   output logic              ex_branch_o,
   output logic [1:0]        ex_aluop_o,
   output logic [1:0]        ex_imm_o,
   output logic              ex_sub_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [REG_AW-1:0] mem_rd_o,
   output logic              wb_regwrite_o,
   output logic              wb_memtoreg_o,
   output logic [REG_AW-1:0] wb_rd_o
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE= 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_NOP  = 7'b0000000;

   typedef struct packed {
      logic              aluSrc;
      logic              memToReg;
      logic              regWrite;
      logic              memRead;
      logic              memWrite;
      logic              branch;
      logic [1:0]        aluOp;
      logic [1:0]        imm;
      logic              sub;
      logic [REG_AW-1:0] rd;
   } ex_t;

   typedef struct packed {
      logic              memToReg;
      logic              regWrite;
      logic              memRead;
      logic              memWrite;
      logic [REG_AW-1:0] rd;
   } mem_t;

   typedef struct packed {
      logic              memToReg;
      logic              regWrite;
      logic [REG_AW-1:0] rd;
   } wb_t;

   ex_t  idWord, exW, exNext;
   mem_t memW;
   wb_t  wbW;
   logic knownOp, carriesRd, useRs1, useRs2;
   logic hazard;
   logic [CNT_W-1:0] illegalCnt;

   always_comb begin
      idWord    = '0;
      knownOp   = 1'b1;
      carriesRd = 1'b0;
      useRs1    = 1'b0;
      useRs2    = 1'b0;
      case (opcode_i)
         OP_R: begin
            idWord.regWrite = 1'b1;
            idWord.aluOp    = 2'b10;
            idWord.imm      = 2'b11;
            idWord.sub      = (funct3_i == 3'b000) && funct7b5_i;
            carriesRd = 1'b1;
            useRs1    = 1'b1;
            useRs2    = 1'b1;
         end
         OP_IALU: begin
            idWord.aluSrc   = 1'b1;
            idWord.regWrite = 1'b1;
            idWord.aluOp    = 2'b10;
            carriesRd = 1'b1;
            useRs1    = 1'b1;
         end
         OP_LOAD: begin
            idWord.aluSrc   = 1'b1;
            idWord.memToReg = 1'b1;
            idWord.regWrite = 1'b1;
            idWord.memRead  = 1'b1;
            carriesRd = 1'b1;
            useRs1    = 1'b1;
         end
         OP_STORE: begin
            idWord.aluSrc   = 1'b1;
            idWord.memWrite = 1'b1;
            idWord.imm      = 2'b01;
            carriesRd = 1'b1;
            useRs1    = 1'b1;
            useRs2    = 1'b1;
         end
         OP_BR: begin
            idWord.branch = 1'b1;
            idWord.aluOp  = 2'b01;
            idWord.imm    = 2'b10;
            carriesRd = 1'b1;
            useRs1    = 1'b1;
            useRs2    = 1'b1;
         end
         OP_NOP:  ;
         default: knownOp = 1'b0;
      endcase
      if (carriesRd) idWord.rd = rd_i;
      // x0 is never written back
      if (rd_i == '0) idWord.regWrite = 1'b0;
      if (!id_valid_i) idWord = '0;
   end

   assign illegal_o = id_valid_i & ~knownOp;

   // Only a real ID instruction can depend on the load in EX
   assign hazard = exW.memRead && (exW.rd != '0) && id_valid_i &&
                   ((useRs1 && (rs1_i == exW.rd)) ||
                    (useRs2 && (rs2_i == exW.rd)));

   assign stall_o = HAZARD_EN && hazard && !flush_i;

   always_comb begin
      exNext = idWord;
      if (flush_i || stall_o) exNext = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exW  <= '0;
         memW <= '0;
         wbW  <= '0;
      end else begin
         exW  <= exNext;
         memW <= '{memToReg: exW.memToReg, regWrite: exW.regWrite,
                   memRead:  exW.memRead,  memWrite: exW.memWrite,
                   rd:       exW.rd};
         wbW  <= '{memToReg: memW.memToReg, regWrite: memW.regWrite,
                   rd:       memW.rd};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegalCnt <= '0;
      end else if (illegal_o && !stall_o && !flush_i &&
                   (illegalCnt != '1)) begin
         illegalCnt <= illegalCnt + CNT_W'(1);
      end
   end

   assign illegal_cnt_o = illegalCnt;
   assign ex_alusrc_o   = exW.aluSrc;
   assign ex_branch_o   = exW.branch;
   assign ex_aluop_o    = exW.aluOp;
   assign ex_imm_o      = exW.imm;
   assign ex_sub_o      = exW.sub;
   assign ex_rd_o       = exW.rd;
   assign mem_read_o    = memW.memRead;
   assign mem_write_o   = memW.memWrite;
   assign mem_rd_o      = memW.rd;
   assign wb_regwrite_o = wbW.regWrite;
   assign wb_memtoreg_o = wbW.memToReg;
   assign wb_rd_o       = wbW.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: scoreboard bench for pipe_ctrl_unit.
// Expected stage words are queued at drive time and retired at WB.
module tb_pipe_ctrl_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       idValid, funct7b5, flush;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rs1, rs2, rd;

   logic       stall, illegal, exAluSrc, exBranch, exSub;
   logic [7:0] cnt;
   logic [1:0] exAluOp, exImm;
   logic [4:0] exRd, memRd, wbRd;
   logic       memRead, memWrite, wbRegWrite, wbMemToReg;

   logic       h0Stall, h0Illegal, h0AluSrc, h0Branch, h0Sub;
   logic [7:0] h0Cnt;
   logic [1:0] h0AluOp, h0Imm;
   logic [4:0] h0ExRd, h0MemRd, h0WbRd;
   logic       h0MemRead, h0MemWrite, h0RegWrite, h0MemToReg;

   pipe_ctrl_unit #(.REG_AW(5), .HAZARD_EN(1'b1), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid_i(idValid),
      .opcode_i(opcode), .funct3_i(funct3), .funct7b5_i(funct7b5),
      .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .flush_i(flush),
      .stall_o(stall), .illegal_o(illegal), .illegal_cnt_o(cnt),
      .ex_alusrc_o(exAluSrc), .ex_branch_o(exBranch),
      .ex_aluop_o(exAluOp), .ex_imm_o(exImm), .ex_sub_o(exSub),
      .ex_rd_o(exRd), .mem_read_o(memRead), .mem_write_o(memWrite),
      .mem_rd_o(memRd), .wb_regwrite_o(wbRegWrite),
      .wb_memtoreg_o(wbMemToReg), .wb_rd_o(wbRd)
   );

   pipe_ctrl_unit #(.REG_AW(5), .HAZARD_EN(1'b0), .CNT_W(8)) dutNoHaz (
      .clk(clk), .rst_n(rst_n), .id_valid_i(idValid),
      .opcode_i(opcode), .funct3_i(funct3), .funct7b5_i(funct7b5),
      .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .flush_i(flush),
      .stall_o(h0Stall), .illegal_o(h0Illegal), .illegal_cnt_o(h0Cnt),
      .ex_alusrc_o(h0AluSrc), .ex_branch_o(h0Branch),
      .ex_aluop_o(h0AluOp), .ex_imm_o(h0Imm), .ex_sub_o(h0Sub),
      .ex_rd_o(h0ExRd), .mem_read_o(h0MemRead),
      .mem_write_o(h0MemWrite), .mem_rd_o(h0MemRd),
      .wb_regwrite_o(h0RegWrite), .wb_memtoreg_o(h0MemToReg),
      .wb_rd_o(h0WbRd)
   );

   typedef struct packed {
      logic       aluSrc, memToReg, regWrite, memRead, memWrite, branch;
      logic [1:0] aluOp, imm;
      logic       sub;
      logic [4:0] rd;
   } ctl_t;

   ctl_t hist[$];
   int   vecs = 0;
   int   errs = 0;
   int   expCnt = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic void expDecode(
      input logic v, input logic [6:0] op, input logic [2:0] f3,
      input logic f7, input logic [4:0] rdd,
      output ctl_t w, output logic ill);
      w   = '0;
      ill = 1'b0;
      case (op)
         7'b0110011: begin
            w.regWrite = 1; w.aluOp = 2'b10; w.imm = 2'b11;
            w.sub = (f3 == 3'b000) && f7; w.rd = rdd;
         end
         7'b0010011: begin
            w.aluSrc = 1; w.regWrite = 1; w.aluOp = 2'b10; w.rd = rdd;
         end
         7'b0000011: begin
            w.aluSrc = 1; w.memToReg = 1; w.regWrite = 1;
            w.memRead = 1; w.rd = rdd;
         end
         7'b0100011: begin
            w.aluSrc = 1; w.memWrite = 1; w.imm = 2'b01; w.rd = rdd;
         end
         7'b1100011: begin
            w.branch = 1; w.aluOp = 2'b01; w.imm = 2'b10; w.rd = rdd;
         end
         7'b0000000: ;
         default: ill = v;
      endcase
      if (rdd == 5'd0) w.regWrite = 1'b0;
      if (!v) w = '0;
   endfunction

   task automatic clearHist();
      hist.delete();
      repeat (3) hist.push_back('0);
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_cnt"}, 32'(cnt), 32'd0);
      chk({tag, "_ex"}, 32'({exAluSrc, exBranch, exAluOp, exImm, exSub,
                             exRd}), 32'd0);
      chk({tag, "_mem"}, 32'({memRead, memWrite, memRd}), 32'd0);
      chk({tag, "_wb"}, 32'({wbRegWrite, wbMemToReg, wbRd}), 32'd0);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(
      input logic v, input logic [6:0] op, input logic [2:0] f3,
      input logic f7, input logic [4:0] r1, input logic [4:0] r2,
      input logic [4:0] rdd, input logic fl, input logic expStall);
      ctl_t w, nxt;
      logic ill;
      idValid = v; opcode = op; funct3 = f3; funct7b5 = f7;
      rs1 = r1; rs2 = r2; rd = rdd; flush = fl;
      #1;
      expDecode(v, op, f3, f7, rdd, w, ill);
      chk("stall", 32'(stall), 32'(expStall));
      chk("stallNoHaz", 32'(h0Stall), 32'd0);
      chk("illegal", 32'(illegal), 32'(ill));
      nxt = (fl || expStall) ? ctl_t'('0) : w;
      if (ill && !expStall && !fl && expCnt != 255) expCnt++;
      @(posedge clk);
      #1;
      hist.push_front(nxt);
      chk("ex", 32'({exAluSrc, exBranch, exAluOp, exImm, exSub, exRd}),
          32'({hist[0].aluSrc, hist[0].branch, hist[0].aluOp,
               hist[0].imm, hist[0].sub, hist[0].rd}));
      chk("mem", 32'({memRead, memWrite, memRd}),
          32'({hist[1].memRead, hist[1].memWrite, hist[1].rd}));
      chk("wb", 32'({wbRegWrite, wbMemToReg, wbRd}),
          32'({hist[2].regWrite, hist[2].memToReg, hist[2].rd}));
      void'(hist.pop_back());
      chk("cnt", 32'(cnt), 32'(expCnt));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, 7'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
   endtask

   localparam logic [6:0] R  = 7'b0110011;
   localparam logic [6:0] IA = 7'b0010011;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;
   localparam logic [6:0] BR = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   initial begin
      idValid = 0; opcode = 0; funct3 = 0; funct7b5 = 0;
      rs1 = 0; rs2 = 0; rd = 0; flush = 0;
      clearHist();
      repeat (2) @(posedge clk);
      #1 chkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // add, sub, I-ALU, branch
      step(1, R, 3'b000, 0, 5'd1, 5'd2, 5'd5, 0, 0);
      step(1, R, 3'b000, 1, 5'd1, 5'd2, 5'd6, 0, 0);
      step(1, IA, 3'b000, 1, 5'd1, 5'd2, 5'd7, 0, 0);
      step(1, BR, 3'b001, 0, 5'd8, 5'd9, 5'd4, 0, 0);
      idle(3);

      // load-use on rs1: one stall, bubble, add re-presented
      step(1, LD, 3'b010, 0, 5'd1, 5'd0, 5'd3, 0, 0);
      step(1, R, 3'b000, 0, 5'd3, 5'd2, 5'd8, 0, 1);
      step(1, R, 3'b000, 0, 5'd3, 5'd2, 5'd8, 0, 0);
      // load-use on store rs2
      step(1, LD, 3'b010, 0, 5'd1, 5'd0, 5'd4, 0, 0);
      step(1, ST, 3'b010, 0, 5'd2, 5'd4, 5'd0, 0, 1);
      step(1, ST, 3'b010, 0, 5'd2, 5'd4, 5'd0, 0, 0);
      // I-ALU does not use rs2: no stall
      step(1, LD, 3'b010, 0, 5'd1, 5'd0, 5'd6, 0, 0);
      step(1, IA, 3'b000, 0, 5'd2, 5'd6, 5'd9, 0, 0);
      idle(3);

      // load to x0: no stall, no writeback
      step(1, LD, 3'b010, 0, 5'd1, 5'd0, 5'd0, 0, 0);
      step(1, R, 3'b000, 0, 5'd0, 5'd0, 5'd11, 0, 0);
      idle(3);

      // flush beats a pending load-use stall
      step(1, LD, 3'b010, 0, 5'd1, 5'd0, 5'd7, 0, 0);
      step(1, ST, 3'b010, 0, 5'd7, 5'd2, 5'd0, 1, 0);
      idle(3);

      // illegal: flushed and invalid ones do not count
      step(1, BAD, 3'b000, 0, 5'd0, 5'd0, 5'd0, 1, 0);
      step(0, BAD, 3'b000, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      for (int i = 0; i < 300; i++)
         step(1, BAD, 3'b000, 0, 5'd1, 5'd2, 5'd3, 0, 0);
      chk("cntSat", 32'(cnt), 32'd255);
      for (int i = 0; i < 3; i++)
         step(0, BAD, 3'b000, 0, 5'd0, 5'd0, 5'd0, 0, 0);

      // async reset with a load in MEM
      step(1, LD, 3'b010, 0, 5'd1, 5'd0, 5'd9, 0, 0);
      step(1, IA, 3'b000, 0, 5'd1, 5'd0, 5'd10, 0, 0);
      chk("memLoadBeforeRst", 32'(memRead), 32'd1);
      idValid = 0;
      #2 rst_n = 1'b0;
      #1 chkAllZero("midReset");
      clearHist();
      expCnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      step(1, R, 3'b000, 0, 5'd1, 5'd2, 5'd12, 0, 0);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
